// File: rtl/multi_motion_sensor.sv
// Multi-channel motion sensor front end.
// Each channel: 2-flop synchronizer -> debounce filter -> STABLE/MOTION/HOLD FSM with a
// saturating 8-bit event counter. A registered hex word shows one selected channel.
// Optional feature: define MOTION_ALARM_LATCH_EN to add a sticky alarm output that sets on
// any new motion event and clears on alarm_clr (set wins over clear).
module multi_motion_sensor #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 200000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] motion_in,
    input  logic [3:0]        sel,
    output logic [NUM_CH-1:0] state_motion,
    output logic [NUM_CH-1:0] state_stable,
    output logic [NUM_CH-1:0] event_pulse,
    output logic [15:0]       sseg_value
`ifdef MOTION_ALARM_LATCH_EN
    ,
    input  logic              alarm_clr,
    output logic              alarm
`endif
);

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

    // Encodings double as the display state code (0 STABLE, 1 MOTION, 2 HOLD).
    typedef enum logic [1:0] {
        StStable = 2'd0,
        StMotion = 2'd1,
        StHold   = 2'd2
    } state_e;

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [NUM_CH-1:0] filt_q;
    logic [DbW-1:0]    db_cnt_q   [NUM_CH];
    state_e            state_q    [NUM_CH];
    logic [HoldW-1:0]  hold_cnt_q [NUM_CH];
    logic [7:0]        count_q    [NUM_CH];
    logic [NUM_CH-1:0] pulse_q;
    logic [15:0]       sseg_q;
    logic [11:0]       sel_field;

    // Two-flop synchronizer on the raw asynchronous inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= motion_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    filt_q[i]   <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Per-channel FSM with registered event strobe and saturating event count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= StStable;
                hold_cnt_q[i] <= '0;
                count_q[i]    <= '0;
            end
        end else begin
            pulse_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_q[i])
                    StStable: begin
                        if (filt_q[i]) begin
                            state_q[i] <= StMotion;
                            pulse_q[i] <= 1'b1;
                            if (count_q[i] != 8'hFF) begin
                                count_q[i] <= count_q[i] + 8'd1;
                            end
                        end
                    end
                    StMotion: begin
                        if (!filt_q[i]) begin
                            state_q[i]    <= StHold;
                            hold_cnt_q[i] <= HoldLoad;
                        end
                    end
                    StHold: begin
                        // Retrigger goes straight back to MOTION without a new event.
                        if (filt_q[i]) begin
                            state_q[i] <= StMotion;
                        end else if (hold_cnt_q[i] == '0) begin
                            state_q[i] <= StStable;
                        end else begin
                            hold_cnt_q[i] <= hold_cnt_q[i] - HoldW'(1);
                        end
                    end
                    default: state_q[i] <= StStable;
                endcase
            end
        end
    end

    // Status decode straight from the state flops.
    always_comb begin
        state_motion = '0;
        state_stable = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_motion[i] = (state_q[i] != StStable);
            state_stable[i] = (state_q[i] == StStable);
        end
    end

    // Display field for the selected channel; out-of-range selects read EEE.
    always_comb begin
        sel_field = 12'hEEE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == 4'(i)) begin
                sel_field = {2'b00, state_q[i], count_q[i]};
            end
        end
    end

    // Registered display word; sel nibble stays live through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sseg_q <= {sel, 12'h000};
        end else begin
            sseg_q <= {sel, sel_field};
        end
    end

    assign event_pulse = pulse_q;
    assign sseg_value  = sseg_q;

`ifdef MOTION_ALARM_LATCH_EN
    logic alarm_q;

    // Sticky alarm: any event sets it, alarm_clr clears it, set has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else if (|pulse_q) begin
            alarm_q <= 1'b1;
        end else if (alarm_clr) begin
            alarm_q <= 1'b0;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule
